// File: rtl/alu_issue_stage.sv
`timescale 1ns/1ps
// alu_issue_stage: registered RV32I decode/issue stage in front of the ALU.
// Decodes OP, OP-IMM, LUI and AUIPC into an ALU op code plus two operands,
// destination register and writeback enable. Everything else is flagged
// illegal and still passes through the handshake.
//
// Build option: define ALU_ISSUE_SKID_EN to add a one-entry skid buffer.
// With it, in_ready is a flop with no path from out_ready. Without it,
// in_ready is derived combinationally from out_ready.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd,
  output logic        wb_en,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } issue_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] map_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_fld;
  logic [4:0] shamt;
  logic       legal;
  issue_t     dec;

  assign opcode = in_instr[6:0];
  assign rd_fld = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign shamt  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  // Decode the incoming instruction into an issue packet.
  always_comb begin
    dec         = '0;
    legal       = 1'b0;
    dec.rd      = rd_fld;
    case (opcode)
      OPC_OP: begin
        dec.a  = in_rs1;
        dec.b  = in_rs2;
        legal  = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.op = map_funct3(funct3, funct7[5]);
      end
      OPC_OPIMM: begin
        dec.a = in_rs1;
        if (funct3 == 3'b001) begin
          dec.b = {27'b0, shamt};
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec.b = {27'b0, shamt};
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end else begin
          dec.b = {{20{in_instr[31]}}, in_instr[31:20]};
          legal = 1'b1;
        end
        // only the shift-right slot reads the alternate bit; ADDI stays ADD
        dec.op = map_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_LUI: begin
        dec.a  = 32'd0;
        dec.b  = {in_instr[31:12], 12'b0};
        dec.op = OP_ADD;
        legal  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a  = in_pc;
        dec.b  = {in_instr[31:12], 12'b0};
        dec.op = OP_ADD;
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      dec.wb_en   = (rd_fld != 5'd0);
      dec.illegal = 1'b0;
    end else begin
      dec.op      = OP_ADD;
      dec.a       = 32'd0;
      dec.b       = 32'd0;
      dec.rd      = 5'd0;
      dec.wb_en   = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  issue_t out_q, out_d;
  logic   out_valid_q, out_valid_d;
  logic   accept;
  logic   drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid_q && out_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // Output register plus skid entry; in_ready tracks the next skid occupancy.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low while the skid is full, so no accept can land here
      if (drain) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || drain) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  // Skid state and registered in_ready; reset holds in_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  logic ready_en_q;

  assign in_ready = ready_en_q && (!out_valid_q || out_ready);

  // Single output register; a stalled output blocks intake through in_ready.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end
`endif

  // Output register; reset clears both payload and valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = out_q.op;
  assign alu_a     = out_q.a;
  assign alu_b     = out_q.b;
  assign rd        = out_q.rd;
  assign wb_en     = out_q.wb_en;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_issue_stage: the driver pushes hand-computed
// expected packets when an instruction is accepted, the monitor pops and
// compares whenever an output transfer happens.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_out = 0;
  exp_t sb[$];

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .rd(rd),
    .wb_en(wb_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] r, input logic w, input logic il);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = r; e.wb = w; e.ill = il;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Present one instruction until accepted; push its expectation at acceptance.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    int n;
    bit ok;
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1 = r1; in_rs2 = r2;
    n = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) sb.push_back(e);
    else begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: instr %h never accepted", ins);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    chk(name, sb.size(), 0);
  endtask

  // Monitor: compare every output transfer and check stability under stall.
  exp_t held;
  bit   stall_prev = 1'b0;
  always @(negedge clk) begin
    exp_t got, e;
    got = {alu_op, alu_a, alu_b, rd, wb_en, illegal};
    if (rst_n) begin
      if (stall_prev && out_valid) begin
        n_checks++;
        if (got !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got %h, expected %h", got, held);
        end
      end
      if (out_valid && out_ready && !flush) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got op=%0d a=%h b=%h, expected no output", alu_op, alu_a, alu_b);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL out[%0d]: got op=%0d a=%h b=%h rd=%0d wb=%0b ill=%0b, expected op=%0d a=%h b=%h rd=%0d wb=%0b ill=%0b",
                     n_out, alu_op, alu_a, alu_b, rd, wb_en, illegal, e.op, e.a, e.b, e.rd, e.wb, e.ill);
          end
        end
        n_out++;
      end
      stall_prev = out_valid && !out_ready && !flush;
      held = got;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    // reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_alu_op", {28'd0, alu_op}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rd_wb_ill", {25'd0, rd, wb_en, illegal}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", {31'd0, in_ready}, 1);

    // directed decode vectors, downstream always ready
    out_ready = 1'b1;
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
    chk("lat_out_valid", {31'd0, out_valid}, 1);
    chk("lat_alu_a", alu_a, 32'd5);
    issue(32'h40435293, 32'h0, 32'h80000000, 32'h0, mk(4'd7, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0));
    issue(32'hFFF00093, 32'h0, 32'h0, 32'h0, mk(4'd0, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
    issue(32'h12345097, 32'h100, 32'h9, 32'h9, mk(4'd0, 32'h100, 32'h12345000, 5'd1, 1'b1, 1'b0));
    issue(32'h0000007F, 32'h0, 32'h11, 32'h22, mk(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    issue(32'h40208233, 32'h0, 32'd10, 32'd3, mk(4'd1, 32'd10, 32'd3, 5'd4, 1'b1, 1'b0));
    issue(32'hABCDE3B7, 32'h0, 32'h55, 32'h66, mk(4'd0, 32'h0, 32'hABCDE000, 5'd7, 1'b1, 1'b0));
    issue(32'h00208033, 32'h0, 32'd1, 32'd2, mk(4'd0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0));
    issue(32'h022081B3, 32'h0, 32'd1, 32'd2, mk(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    issue(32'h01F19113, 32'h0, 32'h3, 32'h0, mk(4'd5, 32'h3, 32'd31, 5'd2, 1'b1, 1'b0));
    issue(32'h0020B4B3, 32'h0, 32'h1, 32'hFFFFFFFF, mk(4'd9, 32'h1, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0));
    issue(32'h7F00F413, 32'h0, 32'hA5A5A5A5, 32'h0, mk(4'd2, 32'hA5A5A5A5, 32'h7F0, 5'd8, 1'b1, 1'b0));
    issue(32'h407352B3, 32'h0, 32'hF0000000, 32'd3, mk(4'd7, 32'hF0000000, 32'd3, 5'd5, 1'b1, 1'b0));
    issue(32'h4020C1B3, 32'h0, 32'd1, 32'd2, mk(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    issue(32'h40008093, 32'h0, 32'd7, 32'd0, mk(4'd0, 32'd7, 32'h400, 5'd1, 1'b1, 1'b0));
    wait_drain("drain_directed");

    // backpressure: 4 back-to-back, downstream stalled for 3 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        issue(32'h40208233, 32'h0, 32'd10, 32'd3, mk(4'd1, 32'd10, 32'd3, 5'd4, 1'b1, 1'b0));
        issue(32'h01F19113, 32'h0, 32'h3, 32'h0, mk(4'd5, 32'h3, 32'd31, 5'd2, 1'b1, 1'b0));
        issue(32'h12345097, 32'h100, 32'h0, 32'h0, mk(4'd0, 32'h100, 32'h12345000, 5'd1, 1'b1, 1'b0));
      end
      begin
        @(posedge clk); @(negedge clk);
`ifdef ALU_ISSUE_SKID_EN
        chk("bp_ready_one_held", {31'd0, in_ready}, 1);
`else
        chk("bp_ready_one_held", {31'd0, in_ready}, 0);
`endif
        @(posedge clk); @(negedge clk);
        chk("bp_ready_two_held", {31'd0, in_ready}, 0);
        chk("bp_out_valid", {31'd0, out_valid}, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_backpressure");

    // flush with output (and skid, when present) full
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1 = 32'd1; in_rs2 = 32'd2;
    @(posedge clk); #1;
    in_instr = 32'h40208233;
    @(posedge clk); #1;
    chk("pre_flush_out_valid", {31'd0, out_valid}, 1);
`ifdef ALU_ISSUE_SKID_EN
    chk("pre_flush_ready", {31'd0, in_ready}, 0);
`endif
    in_instr = 32'hFFF00093;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", {31'd0, out_valid}, 0);
    chk("flush_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    chk("flush_discard", {31'd0, out_valid}, 0);

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    issue(32'h002081B3, 32'h0, 32'hDEADBEEF, 32'h1234, mk(4'd0, 32'hDEADBEEF, 32'h1234, 5'd3, 1'b1, 1'b0));
    chk("pre_reset_valid", {31'd0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("async_rst_out_valid", {31'd0, out_valid}, 0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 0);
    chk("async_rst_alu_a", alu_a, 0);
    chk("async_rst_rd_wb", {26'd0, rd, wb_en}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerst_ready_low", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    chk("rerst_ready_high", {31'd0, in_ready}, 1);
    chk("rerst_no_valid", {31'd0, out_valid}, 0);
    out_ready = 1'b1;
    issue(32'h0020B4B3, 32'h0, 32'd4, 32'd9, mk(4'd9, 32'd4, 32'd9, 5'd9, 1'b1, 1'b0));
    wait_drain("drain_after_reset");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 flush  in  1  synchronous pipeline kill.
REQ-004 in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both are high on a clock edge.
REQ-005 in_instr / in_pc / in_rs1 / in_rs2  in  32 each  RV32I instruction, PC, and register operands.
REQ-006 out_valid / out_ready  out / in  1 / 1  downstream (ALU side) handshake.
REQ-007 alu_op  out  4  ALU op code: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
REQ-008 alu_a / alu_b  out  32 each  ALU operands.
REQ-009 rd  out  5  destination register.
REQ-010 wb_en  out  1  writeback enable.
REQ-011 illegal  out  1  unsupported-encoding flag.

Function
REQ-012 The block SHALL be a registered decode stage; first output one cycle after an in_valid&&in_ready edge.
REQ-013 OP (opcode 0110011) SHALL map funct3/funct7 as follows:
- SUB/SRA need funct7 0100000; all others need 0000000.
- Mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- Operands: a=rs1, b=rs2.
REQ-014 OP-IMM (0010011) SHALL use the same funct3 map with b = sign-extended I-immediate.
- Shifts: b = {27'b0, shamt}.
- SRAI is selected by funct7 0100000.
- ADDI never decodes as SUB.
REQ-015 LUI SHALL issue ADD with a=0, b={imm[31:12],12'b0}.
REQ-016 AUIPC SHALL issue ADD with a=in_pc, b=U-immediate.
REQ-017 Any other opcode, or an illegal funct7 combination, SHALL set illegal=1, wb_en=0, alu_op=ADD, a=b=0, and still handshake.
REQ-018 wb_en SHALL be 1 for every legal instruction with rd!=0, and 0 otherwise.
REQ-019 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-020 Handshake with skid buffer:
- Storage: output register plus one skid entry.
- in_ready = !skid_full, registered with no combinational path from out_ready.
- Accepted data is presented in order; no loss or duplication.
REQ-021 Stall:
- Input accepted while the output register is stalled goes to skid; in_ready then falls next cycle.
- Skid drains into the output register on the first out_ready edge.
REQ-022 Simultaneous accept and drain:
- With output full, skid empty, and both handshakes firing, new data SHALL load the output register directly.
- Skid stays empty.
REQ-023 flush SHALL clear out_valid and the skid valid at the next edge.
- Any input presented that cycle is discarded.
- flush has priority over all handshakes.

Reset
REQ-024 rst_n low SHALL immediately clear out_valid and the skid valid, and force in_ready=0.
REQ-025 During reset: alu_op=0, alu_a=alu_b=0, rd=0, wb_en=0, illegal=0.
REQ-026 in_ready SHALL rise on the first clock edge after rst_n deasserts.
- Reset mid-transfer drops all held instructions.

Configuration
REQ-027 Macro ALU_ISSUE_SKID_EN, when defined, SHALL enable the skid entry per REQ-020..REQ-022.
REQ-028 When ALU_ISSUE_SKID_EN is undefined:
- No skid storage.
- in_ready = !out_valid || out_ready (combinational).
- Throughput and ordering are unchanged; only the out_ready-to-in_ready timing path differs.

Verification
REQ-029 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0, a=5, b=7, rd=3, wb_en=1.
REQ-030 srai x5,x6,4 (0x40435293), rs1=0x80000000 -> alu_op=7, b=4, illegal=0.
- addi x1,x0,-1 (0xFFF00093) -> alu_op=0, b=0xFFFFFFFF.
REQ-031 auipc x1,0x12345 at pc=0x100 -> a=0x100, b=0x12345000, alu_op=0.
- Opcode 0x0000007F -> illegal=1, wb_en=0.
REQ-032 Backpressure: issue 4 back-to-back instructions, hold out_ready=0 for 3 cycles, then release -> all 4 emerge in order, none lost.
- With skid enabled, in_ready deasserts after 2 are held.
REQ-033 Flush while output and skid are full -> next cycle out_valid=0, in_ready=1.
- Assert rst_n=0 mid-burst -> out_valid drops with no clock edge.
